seg_scan_display: RTL
=====================

# seg_scan_display

Parametrised multiplexed 7-segment scan driver: the successor to the fixed 3-digit hex display driver. It drives N common-enable hex digits from one clock. Per-digit decimal points and blanking, PWM brightness, and a one-cycle dead time per slot eliminate ghosting. Inputs are latched once per frame so displayed values never tear. It sits between the debug/status registers and the board's active-low segment and enable pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- DIV_WIDTH, 18, scan prescaler width; one digit slot = 2^DIV_WIDTH clk cycles (~380 Hz slot rate at 100 MHz)
- BRIGHT_WIDTH, 4, brightness resolution; must be < DIV_WIDTH
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous active-low reset
- digits  in  4*NUM_DIGITS  hex nibbles; nibble i shown on digit i
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- blank  in  NUM_DIGITS  1 = digit fully dark, including its dp
- brightness  in  BRIGHT_WIDTH  duty level; 0 = minimum, all-ones = full
- seven_seg  out  8  active-low segments {a,b,c,d,e,f,g,dp}, bit 7 = a, bit 0 = dp
- seven_seg_en  out  NUM_DIGITS  active-low one-hot digit enable; bit i = digit i
- frame_start  out  1  one-cycle pulse when a new frame's inputs are latched

## Operation
- cnt (DIV_WIDTH bits) increments every cycle and wraps. phase = cnt[DIV_WIDTH-1 -: BRIGHT_WIDTH].
- idx advances when cnt == all-ones, wrapping NUM_DIGITS-1 -> 0. idx width = max(1, clog2(NUM_DIGITS)).
- Frame latch: in the cycle where cnt == 0 and idx == 0, digits, dp_in, blank and brightness load into shadow registers, and frame_start is set (registered, visible next cycle). Inputs change nothing else.
- The segment pattern for slot idx comes from shadow nibble idx, using the standard hex font:
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71.
  - These values are bits 7..1 with dp=1. The dp bit is cleared when shadow dp is set.
- Shadow blank[idx] = 1 forces seven_seg = 8'hFF.
- Enable: seven_seg_en = ~(1 << idx) when cnt != 0 and phase <= shadow brightness; otherwise all ones.
  - cnt == 0 is the dead cycle in which segments change.
- NUM_DIGITS = 1: idx is constant 0, and every slot is a frame.

## Timing
- All outputs are registered. Outputs at cycle t+1 reflect cnt, idx and shadow at cycle t.
- Reset, asserted at any time including mid-frame:
  - cnt = 0, idx = 0, shadows = 0, seven_seg = 8'hFF, seven_seg_en = all ones, frame_start = 0.
  - The first frame latch occurs in the first cycle after deassertion.
- Frame period = NUM_DIGITS * 2^DIV_WIDTH cycles. frame_start pulses exactly once per period.
- Brightness duty per slot = ((b+1) * 2^(DIV_WIDTH-BRIGHT_WIDTH) - 1) / 2^DIV_WIDTH. The -1 is the dead cycle.
- A slot never enables a digit with the previous slot's segments.

## Configuration
- SEG_SCAN_LZB_EN defined: leading-zero blanking.
  - At frame latch, an lzb mask register is computed from the incoming values.
  - Digit i is blanked when its nibble and all higher nibbles are 0 and dp_in[i] = 0.
  - Digit 0 is never blanked.
  - Blanked digits output 8'hFF.
- Undefined: no mask register; zeros display as "0".

## Structure
- Package seg_pkg:
  - SEG_OFF = 8'hFF.
  - Function hex_to_seg(nibble) returning the 7-bit font.
  - localparam helper for idx width.
- One sub-module, seg_scan_timer: owns cnt, idx, the frame-latch strobe, the dead-cycle flag and phase. The top level owns shadows, decode and output registers.

## Test plan
Run all scenarios with NUM_DIGITS=4, DIV_WIDTH=4, BRIGHT_WIDTH=2.
- Reset: assert rst_n=0 mid-slot -> outputs FF / 4'b1111 / 0 immediately and for the whole reset. After release, frame_start pulses at cycle 1 and every 64 cycles thereafter.
- Scan: digits=16'h12AF, brightness=3, blank=0 -> slots produce seven_seg/en of 71/1110, 11/1101, 25/1011, 9F/0111. Enable is off on each slot's first cycle.
- Tear-free: change digits to 16'h3456 mid-frame -> the current frame still shows 12AF. The next frame after frame_start shows 6,5,4,3.
- Brightness: brightness=0 -> enable low 3 of 16 cycles per slot. brightness=3 -> 15 of 16. brightness=1 -> 7 of 16.
- DP/blank: dp_in=4'b0010, blank=4'b0100 -> slot1 has bit 0 = 0; slot2 outputs FF with enable still pulsing.
- LZB: digits=16'h0030, dp_in=0.
  - Macro on -> slots 3 and 2 output FF, slot1 outputs 0D (3 with dp off), slot0 outputs 03.
  - Macro off -> slot3 outputs 03.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, hex font and sizing helper for the multiplexed 7-segment scan driver.
package seg_pkg;

    localparam logic [7:0]  SEG_OFF  = 8'hFF;
    localparam int unsigned NIBBLE_W = 4;

    // Digit index width; a single digit still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-low segments {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Display-facing bundle: per-frame value inputs and the active-low pin drives.
interface seg_scan_display_if #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned BRIGHT_WIDTH = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic [BRIGHT_WIDTH-1:0] brightness;
    logic [7:0]              seven_seg;
    logic [NUM_DIGITS-1:0]   seven_seg_en;
    logic                    frame_start;

    modport master (
        output digits, dp_in, blank, brightness,
        input  seven_seg, seven_seg_en, frame_start
    );

    modport slave (
        input  digits, dp_in, blank, brightness,
        output seven_seg, seven_seg_en, frame_start
    );
endinterface

// File: rtl/seg_scan_timer.sv
// Slot timebase: prescaler, digit index, PWM phase, dead-cycle and frame-latch flags.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV_WIDTH    = 18,
    parameter int unsigned BRIGHT_WIDTH = 4,
    parameter int unsigned IDX_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [IDX_W-1:0]        idx_o,
    output logic [BRIGHT_WIDTH-1:0] phase_o,
    output logic                    dead_o,
    output logic                    frame_latch_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 dead_q, dead_d;
    logic                 latch_q, latch_d;

    // Flags are precomputed from next state so they are register outputs.
    always_comb begin
        cnt_d   = cnt_q + DIV_WIDTH'(1);
        idx_d   = idx_q;
        if (cnt_q == '1) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        dead_d  = (cnt_d == '0);
        latch_d = dead_d && (idx_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            dead_q  <= 1'b1;
            latch_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dead_q  <= dead_d;
            latch_q <= latch_d;
        end
    end

    assign idx_o         = idx_q;
    assign phase_o       = cnt_q[DIV_WIDTH-1 -: BRIGHT_WIDTH];
    assign dead_o        = dead_q;
    assign frame_latch_o = latch_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed N-digit hex scan driver with frame-latched shadows, PWM and dead time.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV_WIDTH    = 18,
    parameter int unsigned BRIGHT_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_display_if.slave disp
);

    localparam int unsigned IDX_W = idx_width(NUM_DIGITS);

    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_WIDTH-1:0] phase;
    logic                    dead;
    logic                    frame_latch;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DIV_WIDTH    (DIV_WIDTH),
        .BRIGHT_WIDTH (BRIGHT_WIDTH),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .idx_o         (idx),
        .phase_o       (phase),
        .dead_o        (dead),
        .frame_latch_o (frame_latch)
    );

    logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]               dp_q, dp_d;
    logic [NUM_DIGITS-1:0]               blank_q, blank_d;
    logic [BRIGHT_WIDTH-1:0]             bright_q, bright_d;
    logic [NUM_DIGITS-1:0]               dark_c;
    logic [7:0]                          seg_q, seg_d;
    logic [NUM_DIGITS-1:0]               en_q, en_d;
    logic                                fs_q, fs_d;

`ifdef SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lzb_q, lzb_d;

    // A digit goes dark when it and everything above it is zero and it has no dp.
    always_comb begin : lzb_next
        logic zero_run;
        zero_run = 1'b1;
        lzb_d    = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp.digits[4*i +: 4] == 4'h0);
            lzb_d[i] = zero_run & ~disp.dp_in[i] & (i != 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lzb_q <= '0;
        end else if (frame_latch) begin
            lzb_q <= lzb_d;
        end
    end

    assign dark_c = blank_q | lzb_q;
`else
    assign dark_c = blank_q;
`endif

    // Shadow load and next output word for the current slot.
    always_comb begin
        dig_d    = dig_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        bright_d = bright_q;
        if (frame_latch) begin
            dig_d    = disp.digits;
            dp_d     = disp.dp_in;
            blank_d  = disp.blank;
            bright_d = disp.brightness;
        end

        seg_d = {hex_to_seg(dig_q[idx]), ~dp_q[idx]};
        if (dark_c[idx]) begin
            seg_d = SEG_OFF;
        end

        en_d = '1;
        if (!dead && (phase <= bright_q)) begin
            en_d = ~(NUM_DIGITS'(1) << idx);
        end

        fs_d = frame_latch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q    <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            bright_q <= '0;
            seg_q    <= SEG_OFF;
            en_q     <= '1;
            fs_q     <= 1'b0;
        end else begin
            dig_q    <= dig_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            bright_q <= bright_d;
            seg_q    <= seg_d;
            en_q     <= en_d;
            fs_q     <= fs_d;
        end
    end

    assign disp.seven_seg    = seg_q;
    assign disp.seven_seg_en = en_q;
    assign disp.frame_start  = fs_q;

endmodule
